// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared PWM constants and types
// used by the PWM generator and the dead-time stage
package pwm_gen_pkg;

  localparam int W_DEF       = 10;
  localparam int MIN_OFF_DEF = 4;
  localparam int RUN_MIN_PER = 2;

  typedef enum logic [1:0] {
    BND_NONE,
    BND_START,
    BND_WRAP
  } bnd_e;

endpackage

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg: shadow period/duty with pending flag
// copied to the active pair only at a period boundary
module pwm_shadow_reg
  import pwm_gen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         apply_i,
  input  logic [W-1:0] per_i,
  input  logic [W-1:0] duty_i,
  output logic [W-1:0] per_o,
  output logic [W-1:0] per_nxt_o,
  output logic [W-1:0] duty_nxt_o,
  output logic         upd_o
);

  logic [W-1:0] sh_per_q;
  logic [W-1:0] sh_duty_q;
  logic [W-1:0] per_q;
  logic [W-1:0] duty_q;
  logic         pend_q;
  logic         upd_q;
  logic         take;

  assign take       = apply_i && pend_q;
  assign per_nxt_o  = take ? sh_per_q : per_q;
  assign duty_nxt_o = take ? sh_duty_q : duty_q;
  assign per_o      = per_q;
  assign upd_o      = upd_q;

  // capture loads, apply the pending pair at a boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_per_q  <= '0;
      sh_duty_q <= '0;
      per_q     <= '0;
      duty_q    <= '0;
      pend_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= take;
      if (take) begin
        per_q  <= sh_per_q;
        duty_q <= sh_duty_q;
      end
      if (load_i) begin
        sh_per_q  <= per_i;
        sh_duty_q <= duty_i;
        pend_q    <= 1'b1;
      end else if (take) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: period/duty PWM with shadowed updates,
// duty clamp for minimum off time, registered outputs
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] duty_in,
  input  logic         load,
  output logic         S,
  output logic         cycle_start,
  output logic         upd_ack,
  output logic         running
);

  // never allow a zero off time, so S cannot stick high
  localparam int MO = (MIN_OFF < 1) ? 1 : MIN_OFF;
  localparam int RP = RUN_MIN_PER;
  localparam logic [W:0] MO_X = MO[W:0];
  localparam logic [W:0] RP_X = RP[W:0];
  localparam logic [W:0] ONE_X = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         en_q;
  logic         s_q;
  logic         s_d;
  logic         cs_q;
  logic         cs_d;
  logic         run_q;
  logic         run_d;

  logic [W-1:0] per_act;
  logic [W-1:0] per_nxt;
  logic [W-1:0] duty_nxt;
  logic [W:0]   per_x;
  logic [W:0]   cnt_x;
  logic [W:0]   pn_x;
  logic [W:0]   dn_x;
  logic [W:0]   lim_x;
  logic [W:0]   eff_x;
  logic         last;
  bnd_e         bnd;

  pwm_shadow_reg #(
    .W (W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .apply_i    (bnd != BND_NONE),
    .per_i      (period_in),
    .duty_i     (duty_in),
    .per_o      (per_act),
    .per_nxt_o  (per_nxt),
    .duty_nxt_o (duty_nxt),
    .upd_o      (upd_ack)
  );

  assign per_x = {1'b0, per_act};
  assign cnt_x = {1'b0, cnt_q};
  assign pn_x  = {1'b0, per_nxt};
  assign dn_x  = {1'b0, duty_nxt};
  // per_act=0 wraps to all ones here, which cnt never reaches
  assign last  = (cnt_x == (per_x - ONE_X));

  // classify this cycle as restart, wrap or neither
  always_comb begin
    bnd = BND_NONE;
    unique case (1'b1)
      (en && !en_q):        bnd = BND_START;
      (en && en_q && last): bnd = BND_WRAP;
      default:              bnd = BND_NONE;
    endcase
  end

  // next count, clamped duty and next output levels
  always_comb begin
    cnt_d = '0;
    if (en && bnd == BND_NONE && per_x >= RP_X) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    lim_x = pn_x - MO_X;
    eff_x = '0;
    if (pn_x > MO_X) begin
      eff_x = (dn_x < lim_x) ? dn_x : lim_x;
    end
    run_d = en && (pn_x >= RP_X);
    cs_d  = run_d && (bnd != BND_NONE);
    s_d   = run_d && ({1'b0, cnt_d} < eff_x);
  end

  // counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      s_q   <= 1'b0;
      cs_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en;
      s_q   <= s_d;
      cs_q  <= cs_d;
      run_q <= run_d;
    end
  end

  assign S           = s_q;
  assign cycle_start = cs_q;
  assign running     = run_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed stimulus, per-cycle model
// compare plus hand-computed period statistics
module tb_pwm_gen;

  localparam int W  = 10;
  localparam int MO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] period_in;
  logic [W-1:0] duty_in;
  logic         S;
  logic         cycle_start;
  logic         upd_ack;
  logic         running;

  int total = 0;
  int bad   = 0;
  int hi, ncs, nua, nrun;

  pwm_gen #(
    .W       (W),
    .MIN_OFF (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .load        (load),
    .S           (S),
    .cycle_start (cycle_start),
    .upd_ack     (upd_ack),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference behaviour: shadow/active pair, position in period
  int  sh_per = 0, sh_duty = 0, per = 0, duty = 0, pos = 0;
  bit  pend = 0, en_prev = 0;
  bit  e_s = 0, e_cs = 0, e_ua = 0, e_run = 0;

  initial begin
    forever begin
      bit bnd;
      int eff;
      @(posedge clk);
      if (rst) begin
        sh_per = 0; sh_duty = 0; per = 0; duty = 0; pos = 0;
        pend = 0; en_prev = 0;
        e_s = 0; e_cs = 0; e_ua = 0; e_run = 0;
      end else begin
        bnd  = en && (!en_prev || (pos == per - 1));
        e_ua = 0;
        if (bnd && pend) begin
          per = sh_per; duty = sh_duty; pend = 0; e_ua = 1;
        end
        if (load) begin
          sh_per = int'(period_in); sh_duty = int'(duty_in); pend = 1;
        end
        if (!en || bnd || per < 2) pos = 0;
        else pos = pos + 1;
        eff   = (per <= MO) ? 0 : ((duty < per - MO) ? duty : per - MO);
        e_run = en && per >= 2;
        e_cs  = bnd && e_run;
        e_s   = e_run && pos < eff;
        en_prev = en;
      end
      #1;
      chk("model_S", int'(S), int'(e_s));
      chk("model_cycle_start", int'(cycle_start), int'(e_cs));
      chk("model_upd_ack", int'(upd_ack), int'(e_ua));
      chk("model_running", int'(running), int'(e_run));
    end
  end

  task automatic measure(input int n);
    hi = 0; ncs = 0; nua = 0; nrun = 0;
    for (int i = 0; i < n; i++) begin
      hi   += int'(S);
      ncs  += int'(cycle_start);
      nua  += int'(upd_ack);
      nrun += int'(running);
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int p, input int d);
    period_in = p[W-1:0];
    duty_in   = d[W-1:0];
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({S, cycle_start, upd_ack, running}), 0);

    // basic run 10/3
    rst = 1'b0;
    do_load(10, 3);
    en = 1'b1;
    @(negedge clk);
    chk("basic_first_ack", int'(upd_ack), 1);
    chk("basic_first_cs", int'(cycle_start), 1);
    measure(20);
    chk("basic_hi", hi, 6);
    chk("basic_cs", ncs, 2);
    chk("basic_ack", nua, 1);
    chk("basic_run", nrun, 20);

    // mid-period load at cnt=5; period widened to 12 so
    // duty 7 is not clipped by the minimum off time
    measure(5);
    chk("mid_head_hi", hi, 3);
    do_load(12, 7);
    measure(4);
    chk("mid_tail_hi", hi, 0);
    chk("mid_tail_ack", nua, 0);
    chk("mid_ack_at_cnt0", int'(upd_ack), 1);
    chk("mid_cs_at_cnt0", int'(cycle_start), 1);
    measure(12);
    chk("mid_next_hi", hi, 7);
    chk("mid_next_cs", ncs, 1);

    // clamp: 10/9 -> high 6
    do_load(10, 9);
    measure(11);
    measure(10);
    chk("clamp_hi", hi, 6);
    chk("clamp_ack", nua, 1);

    // duty 0 -> never high
    do_load(10, 0);
    measure(9);
    measure(10);
    chk("zero_hi", hi, 0);
    chk("zero_run", nrun, 10);

    // enable drop with S high at cnt=1
    do_load(10, 3);
    measure(9);
    @(negedge clk);
    chk("drop_pre_S", int'(S), 1);
    en = 1'b0;
    @(negedge clk);
    chk("drop_S", int'(S), 0);
    chk("drop_run", int'(running), 0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("restart_cs", int'(cycle_start), 1);
    chk("restart_S", int'(S), 1);
    measure(10);
    chk("restart_hi", hi, 3);

    // degenerate periods 1 and 0
    en = 1'b0;
    do_load(1, 0);
    en = 1'b1;
    @(negedge clk);
    chk("per1_ack", int'(upd_ack), 1);
    chk("per1_run", int'(running), 0);
    measure(6);
    chk("per1_runs", nrun, 0);
    chk("per1_cs", ncs, 0);
    do_load(0, 0);
    measure(4);
    chk("per0_ack", nua, 1);
    chk("per0_run", nrun + ncs + hi, 0);
    do_load(8, 3);
    measure(4);
    chk("per0_hold_ack", nua, 0);
    chk("per0_hold_run", nrun, 0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("per8_run", int'(running), 1);
    chk("per8_cs", int'(cycle_start), 1);
    chk("per8_ack", int'(upd_ack), 1);

    // reset at cnt=2 with pending load and a load under reset
    @(negedge clk);
    period_in = 10'd10; duty_in = 10'd5; load = 1'b1;
    @(negedge clk);
    chk("rst_pre_S", int'(S), 1);
    period_in = 10'd9; duty_in = 10'd4; rst = 1'b1;
    @(negedge clk);
    load = 1'b0; rst = 1'b0;
    chk("rst_outs", int'({S, cycle_start, upd_ack, running}), 0);
    measure(6);
    chk("rst_discard_run", nrun, 0);
    chk("rst_discard_ack", nua, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
